// File: rtl/serial_frame_builder.sv
// Purpose : buffers {chan, value} samples and wraps each into a 6-byte frame
//           (header, chan, value lo/hi, seq, XOR) for the serial transmitter.
// Latency : sample written at edge N -> tx_new_data high after edge N+2.
// Backpr. : in_ready = !full; offers while full are dropped and counted in
//           drop_cnt. Frames wait for tx_busy low; one frame in flight at a time.
// Ports   : clk, rst (async, active low) | in_valid/in_chan/in_value/in_ready
//           sample side | tx_busy, tx_new_data, tx_data transmitter side |
//           seq_num, drop_cnt status.

// Purpose : generic synchronous FIFO, power-of-2 depth, no bypass.
// Latency : written data is visible at rdat the cycle after the push edge.
// Backpr. : caller must not push when full or pop when empty.
module sff_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdat,
    output logic [W-1:0] rdat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: contents are qualified by cnt.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdat;
    end

    assign rdat  = mem[rptr];
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
endmodule

module serial_frame_builder #(
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] HEADER       = 8'hA5,
    parameter int         BUSY_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_chan,
    input  logic [15:0] in_value,
    output logic        in_ready,
    input  logic        tx_busy,
    output logic        tx_new_data,
    output logic [47:0] tx_data,
    output logic [7:0]  seq_num,
    output logic [7:0]  drop_cnt
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEND      = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_RESEND    = 3'd3,
        S_WAIT_DONE = 3'd4
    } state_t;

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    state_t        state;
    state_t        state_nxt;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          head_vld;
    logic [23:0]   head_dat;
    logic [7:0]    seq;
    logic [TW-1:0] timer;
    logic          load;
    logic          pulse;
    logic          accept;
    logic          timer_clr;
    logic          timer_inc;

    assign in_ready = !fifo_full;
    assign push     = in_valid && !fifo_full;

    sff_fifo #(.DEPTH(FIFO_DEPTH), .W(24)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (load),
        .wdat  ({in_chan, in_value}),
        .rdat  (head_dat),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // head_dat = {chan, value}; byte 5 is the XOR of bytes 0..4.
    function automatic logic [47:0] build_frame(input logic [23:0] s, input logic [7:0] sq);
        logic [7:0] ch;
        logic [7:0] lo;
        logic [7:0] hi;
        ch = s[23:16];
        lo = s[7:0];
        hi = s[15:8];
        return {HEADER ^ ch ^ lo ^ hi ^ sq, sq, hi, lo, ch, HEADER};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        pulse     = 1'b0;
        accept    = 1'b0;
        timer_clr = 1'b0;
        timer_inc = 1'b0;
        case (state)
            S_IDLE: begin
                if (head_vld && !fifo_empty && !tx_busy) begin
                    load      = 1'b1;
                    pulse     = 1'b1;
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                timer_clr = 1'b1;
                state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    accept    = 1'b1;
                    state_nxt = S_WAIT_DONE;
                end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
                    state_nxt = S_RESEND;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            S_RESEND: begin
                // Same tx_data and seq; only the strobe is repeated.
                if (!tx_busy) begin
                    pulse     = 1'b1;
                    state_nxt = S_SEND;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_new_data <= 1'b0;
            tx_data     <= '0;
            seq_num     <= '0;
            seq         <= '0;
            timer       <= '0;
            drop_cnt    <= '0;
            head_vld    <= 1'b0;
        end else begin
            // The FSM looks at the head one cycle after it lands, which sets the
            // two-edge sample-to-strobe latency. It can only go stale right after
            // a pop, when the FSM is at least three cycles away from IDLE.
            head_vld    <= !fifo_empty;
            tx_new_data <= pulse;
            if (load) tx_data <= build_frame(head_dat, seq);
            if (timer_clr)      timer <= '0;
            else if (timer_inc) timer <= timer + 1'b1;
            if (accept) begin
                seq_num <= seq;
                seq     <= seq + 8'd1;
            end
            if (in_valid && fifo_full && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule
